// File: rtl/adder_bist_pkg.sv
// Shared types and sizes for the 2-bit adder self-check controller.
`timescale 1ns/1ps
package adder_bist_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } bist_state_t;

    localparam int VEC_COUNT = 16;
    localparam int VEC_IDX_W = 4;
    localparam int RES_W     = 3;

endpackage

// File: rtl/adder_bist_controller_golden.sv
// Reference 2-bit adder: expected {co,s1,s0} for the operands encoded in vec_idx.
`timescale 1ns/1ps
module adder_golden_2bit
    import adder_bist_pkg::*;
(
    input  logic [VEC_IDX_W-1:0] vec_idx,
    output logic [RES_W-1:0]     sum
);

    assign sum = {1'b0, vec_idx[3:2]} + {1'b0, vec_idx[1:0]};

endmodule

// File: rtl/adder_bist_controller.sv
// Sweeps all 16 operand pairs into a 2-bit adder and checks each result against a golden sum.
// Optional first-failure capture ports are built when ADDER_BIST_FIRST_FAIL_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start; results of the last sweep held
// DRIVE  | operand registers load from vec_idx on exit
// SETTLE | operands held while the adder settles (SETTLE_CYCLES cycles)
// CHECK  | adder result compared with the golden sum
// DONE   | sweep over; done pulse, pass and cleared operands issued on exit
`timescale 1ns/1ps
module adder_bist_controller
    import adder_bist_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 a0,
    output logic                 a1,
    output logic                 b0,
    output logic                 b1,
    input  logic                 s0,
    input  logic                 s1,
    input  logic                 co,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [VEC_IDX_W-1:0] vec_idx
`ifdef ADDER_BIST_FIRST_FAIL_EN
    ,
    output logic [VEC_IDX_W-1:0] first_fail_vec,
    output logic [RES_W-1:0]     first_fail_got
`endif
);

    localparam int TMR_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TMR_W-1:0]     SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_IDX_W-1:0] LAST_VEC    = VEC_IDX_W'(VEC_COUNT - 1);

    bist_state_t        state, state_nxt;
    logic [TMR_W-1:0]   settle_tmr;
    logic [RES_W-1:0]   golden_sum;
    logic [RES_W-1:0]   result;
    logic               mismatch;
    logic               last_vec;
    logic               err_sat;

    adder_golden_2bit u_golden (
        .vec_idx (vec_idx),
        .sum     (golden_sum)
    );

    assign result   = {co, s1, s0};
    assign mismatch = (result != golden_sum);
    assign last_vec = (vec_idx == LAST_VEC);
    assign err_sat  = &err_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = DRIVE;
            DRIVE:   state_nxt = SETTLE;
            SETTLE:  if (settle_tmr == '0) state_nxt = CHECK;
            CHECK:   state_nxt = last_vec ? DONE : DRIVE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef ADDER_BIST_FIRST_FAIL_EN
    logic first_fail_seen;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {a1, a0, b1, b0} <= '0;
            settle_tmr       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_cnt          <= '0;
            vec_idx          <= '0;
`ifdef ADDER_BIST_FIRST_FAIL_EN
            first_fail_seen  <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_got   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        vec_idx         <= '0;
                        err_cnt         <= '0;
                        pass            <= 1'b0;
                        busy            <= 1'b1;
`ifdef ADDER_BIST_FIRST_FAIL_EN
                        first_fail_seen <= 1'b0;
                        first_fail_vec  <= '0;
                        first_fail_got  <= '0;
`endif
                    end
                end
                DRIVE: begin
                    {a1, a0, b1, b0} <= vec_idx;
                    settle_tmr       <= SETTLE_LOAD;
                end
                SETTLE: begin
                    if (settle_tmr != '0) settle_tmr <= settle_tmr - 1'b1;
                end
                CHECK: begin
                    if (mismatch) begin
                        if (!err_sat) err_cnt <= err_cnt + 1'b1;
`ifdef ADDER_BIST_FIRST_FAIL_EN
                        if (!first_fail_seen) begin
                            first_fail_seen <= 1'b1;
                            first_fail_vec  <= vec_idx;
                            first_fail_got  <= result;
                        end
`endif
                    end
                    // index stops at the last vector; no wrap inside a sweep
                    if (!last_vec) vec_idx <= vec_idx + 1'b1;
                end
                DONE: begin
                    done             <= 1'b1;
                    pass             <= (err_cnt == '0);
                    busy             <= 1'b0;
                    {a1, a0, b1, b0} <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_bist_controller.sv
// Bench for adder_bist_controller: behavioural faulty-adder models on two instances with randomized fault patterns.
`timescale 1ns/1ps
module tb_adder_bist_controller;

    localparam int S1 = 3;
    localparam int W1 = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;

    logic a0_0, a1_0, b0_0, b1_0, s0_0, s1_0, co_0, busy0, done0, pass0;
    logic [4:0] err0;
    logic [3:0] idx0;
    logic a0_1, a1_1, b0_1, b1_1, s0_1, s1_1, co_1, busy1, done1, pass1;
    logic [W1-1:0] err1;
    logic [3:0] idx1;
`ifdef ADDER_BIST_FIRST_FAIL_EN
    logic [3:0] ffv0, ffv1;
    logic [2:0] ffg0, ffg1;
`endif

    logic [2:0] xm0 [16];
    logic [2:0] xm1 [16];
    logic [2:0] sa0_0 = '0, sa1_0 = '0, sa0_1 = '0, sa1_1 = '0;

    int checks = 0;
    int errors = 0;
    int cur = 0;

    int r_done_cyc, r_done2_cyc, r_done_cnt, r_busy_gap, r_busy_at_done, r_bad_runs, r_runs;

    always #5 clk = ~clk;

    adder_bist_controller u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0),
        .a0(a0_0), .a1(a1_0), .b0(b0_0), .b1(b1_0),
        .s0(s0_0), .s1(s1_0), .co(co_0),
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0), .vec_idx(idx0)
`ifdef ADDER_BIST_FIRST_FAIL_EN
        , .first_fail_vec(ffv0), .first_fail_got(ffg0)
`endif
    );

    adder_bist_controller #(.SETTLE_CYCLES(S1), .ERR_CNT_W(W1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1),
        .a0(a0_1), .a1(a1_1), .b0(b0_1), .b1(b1_1),
        .s0(s0_1), .s1(s1_1), .co(co_1),
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1), .vec_idx(idx1)
`ifdef ADDER_BIST_FIRST_FAIL_EN
        , .first_fail_vec(ffv1), .first_fail_got(ffg1)
`endif
    );

    // adder under test: true sum, then per-vector bit flips and stuck-at masks
    function automatic logic [2:0] adder_model(input int v, input logic [2:0] x,
                                               input logic [2:0] z, input logic [2:0] o);
        logic [2:0] sum;
        sum = 3'((v / 4) + (v % 4));
        return ((sum ^ x) & ~z) | o;
    endfunction

    logic [3:0] op0, op1;
    assign op0 = {a1_0, a0_0, b1_0, b0_0};
    assign op1 = {a1_1, a0_1, b1_1, b0_1};
    always_comb {co_0, s1_0, s0_0} = adder_model(int'(op0), xm0[op0], sa0_0, sa1_0);
    always_comb {co_1, s1_1, s0_1} = adder_model(int'(op1), xm1[op1], sa0_1, sa1_1);

    logic       c_done, c_busy;
    logic [3:0] c_idx, c_ops;
    assign c_done = (cur != 0) ? done1 : done0;
    assign c_busy = (cur != 0) ? busy1 : busy0;
    assign c_idx  = (cur != 0) ? idx1  : idx0;
    assign c_ops  = (cur != 0) ? op1   : op0;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (cur != 0) start1 = v;
        else start0 = v;
    endtask

    task automatic run_sweep(input int ncyc, input int pulse_vec, input bit hold, input int run_len);
        int prev, len, exp_v;
        bit pulsed;
        r_done_cyc = -1; r_done2_cyc = -1; r_done_cnt = 0; r_busy_gap = 0;
        r_busy_at_done = -1; r_bad_runs = 0; r_runs = 0;
        prev = 0; len = 0; exp_v = 1; pulsed = 0;
        @(negedge clk); set_start(1'b1);
        @(posedge clk); #1; if (!hold) set_start(1'b0);
        for (int i = 1; i <= ncyc; i++) begin
            @(posedge clk); #1; if (!hold) set_start(1'b0);
            @(negedge clk);
            if (c_done) begin
                r_done_cnt++;
                if (r_done_cnt == 2) r_done2_cyc = i;
                if (r_done_cyc < 0) begin
                    r_done_cyc = i;
                    r_busy_at_done = int'(c_busy);
                end
            end
            if (r_done_cyc < 0 && !c_busy) r_busy_gap++;
            if (r_done_cyc < 0 || r_done_cyc == i) begin
                if (int'(c_ops) == prev) len++;
                else begin
                    if (prev != 0) begin
                        r_runs++;
                        if (len != run_len || prev != exp_v) r_bad_runs++;
                        exp_v++;
                    end
                    prev = int'(c_ops);
                    len = 1;
                end
            end
            if (pulse_vec >= 0 && !pulsed && int'(c_idx) == pulse_vec) begin
                set_start(1'b1);
                pulsed = 1;
            end
        end
    endtask

    task automatic check_result(input string tag);
        int cnt, e_err, e_ffv, e_ffg, w, sat;
        logic [2:0] got;
        cnt = 0; e_ffv = 0; e_ffg = 0;
        w = (cur != 0) ? W1 : 5;
        for (int v = 0; v < 16; v++) begin
            got = (cur != 0) ? adder_model(v, xm1[v], sa0_1, sa1_1)
                             : adder_model(v, xm0[v], sa0_0, sa1_0);
            if (int'(got) != (v / 4) + (v % 4)) begin
                if (cnt == 0) begin
                    e_ffv = v;
                    e_ffg = int'(got);
                end
                cnt++;
            end
        end
        sat = (1 << w) - 1;
        e_err = (cnt > sat) ? sat : cnt;
        chk({tag, "_err_cnt"}, (cur != 0) ? int'(err1) : int'(err0), e_err);
        chk({tag, "_pass"}, (cur != 0) ? int'(pass1) : int'(pass0), (cnt == 0) ? 1 : 0);
`ifdef ADDER_BIST_FIRST_FAIL_EN
        chk({tag, "_ff_vec"}, (cur != 0) ? int'(ffv1) : int'(ffv0), e_ffv);
        chk({tag, "_ff_got"}, (cur != 0) ? int'(ffg1) : int'(ffg0), e_ffg);
`else
        if (e_ffv < 0 || e_ffg < 0) $display("note: unexpected model state");
`endif
    endtask

    task automatic clear_faults();
        for (int v = 0; v < 16; v++) begin
            xm0[v] = '0;
            xm1[v] = '0;
        end
        sa0_0 = '0; sa1_0 = '0; sa0_1 = '0; sa1_1 = '0;
    endtask

    task automatic randomize_faults();
        for (int v = 0; v < 16; v++) begin
            if ($urandom_range(0, 2) == 0) begin
                if (cur != 0) xm1[v] = 3'($urandom_range(1, 7));
                else xm0[v] = 3'($urandom_range(1, 7));
            end else begin
                if (cur != 0) xm1[v] = '0;
                else xm0[v] = '0;
            end
        end
    endtask

    initial begin
        bit found;
        clear_faults();

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs0", int'({busy0, done0, pass0, err0, idx0, op0}), 0);
        chk("reset_outs1", int'({busy1, done1, pass1, err1, idx1, op1}), 0);
        rst_n = 1'b1;

        // clean sweep, defaults
        cur = 0;
        run_sweep(55, -1, 0, 3);
        chk("clean_done_cycle", r_done_cyc, 49);
        chk("clean_done_count", r_done_cnt, 1);
        chk("clean_busy_at_done", r_busy_at_done, 0);
        chk("clean_busy_gap", r_busy_gap, 0);
        chk("clean_vec_runs", r_runs, 15);
        chk("clean_bad_runs", r_bad_runs, 0);
        check_result("clean");
        chk("clean_pass_held", int'(pass0), 1);

        // co stuck-at-0
        sa0_0 = 3'b100;
        run_sweep(55, -1, 0, 3);
        chk("co_sa0_err_direct", int'(err0), 6);
        check_result("co_sa0");
        clear_faults();

        // start pulse mid-sweep is ignored
        run_sweep(55, 5, 0, 3);
        chk("midstart_done_cycle", r_done_cyc, 49);
        chk("midstart_done_count", r_done_cnt, 1);
        check_result("midstart");

        // randomized fault patterns
        for (int k = 0; k < 4; k++) begin
            randomize_faults();
            run_sweep(55, -1, 0, 3);
            chk("rand0_done_cycle", r_done_cyc, 49);
            check_result("rand0");
        end
        clear_faults();

        // start held high re-arms on every IDLE visit
        run_sweep(105, -1, 1, 3);
        start0 = 1'b0;
        chk("rearm_done_count", r_done_cnt, 2);
        chk("rearm_second_done", r_done2_cyc, 99);
        found = 0;
        for (int i = 0; i < 80 && !found; i++) begin
            @(negedge clk);
            if (!busy0) found = 1;
        end
        chk("rearm_drain", int'(found), 1);

        // reset at vector 9 aborts the sweep
        @(negedge clk); start0 = 1'b1;
        @(posedge clk); #1; start0 = 1'b0;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            if (idx0 == 4'd9) found = 1;
        end
        chk("reach_vec9", int'(found), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_outs0", int'({busy0, done0, pass0, err0, idx0, op0}), 0);
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        run_sweep(55, -1, 0, 3);
        chk("post_reset_done_cycle", r_done_cyc, 49);
        check_result("post_reset");

        // second instance: SETTLE_CYCLES=3, ERR_CNT_W=2
        cur = 1;
        run_sweep(86, -1, 0, S1 + 2);
        chk("s3_done_cycle", r_done_cyc, 81);
        chk("s3_vec_runs", r_runs, 15);
        chk("s3_bad_runs", r_bad_runs, 0);
        check_result("s3_clean");

        sa1_1 = 3'b001;
        run_sweep(86, -1, 0, S1 + 2);
        chk("s0_sa1_err_direct", int'(err1), 3);
        check_result("s0_sa1");
        clear_faults();

        for (int k = 0; k < 3; k++) begin
            randomize_faults();
            run_sweep(86, -1, 0, S1 + 2);
            check_result("rand1");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
